// File: rtl/host_pwr_regs.sv
// host_pwr_regs
//   Host-bus register slave plus power-sequencing FSM for one switchable domain.
//
//   Register window (BASE_ADDR + offset):
//     0 ID       RO  ID_VALUE
//     1 SCRATCH  RW  16 bits
//     2 PWR_CTRL RW  bit0 pd_req
//     3 PWR_STAT RO  [2:0] FSM state, [3] timeout sticky, [4] pwr_ack
//     4 ERR_CNT  RW  any write clears; saturating bus-error counter
//     5-7        --  read as 0, every strobe counts as an error
//
//   Optional build macro: HOST_PWR_TIMEOUT_EN enables the pwr_ack timeout
//   counter and the PWR_STAT[3] sticky flag (otherwise that bit reads 0).
//
//   Ports:
//     clk      bus and block clock
//     reset    synchronous, active-high reset
//     wr_n     host write strobe, active low
//     rd_n     host read strobe, active low
//     address  16-bit host address
//     data     16-bit bidirectional host data, driven only for decoded reads
//     pwr_ack  1 = domain powered, 0 = domain off
//     iso_en   isolation enable
//     save     one-cycle retention save pulse
//     restore  one-cycle retention restore pulse
//     pwr_off  power-switch off request
module host_pwr_regs #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter logic [15:0] ID_VALUE  = 16'hC0DE,
  parameter int unsigned ISO_CYC   = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_n,
  input  logic        rd_n,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        pwr_ack,
  output logic        iso_en,
  output logic        save,
  output logic        restore,
  output logic        pwr_off
);

  // Elaboration-time parameter legality.
  if (ISO_CYC < 1 || ISO_CYC > 255) begin : g_bad_iso_cyc
    $error("host_pwr_regs: ISO_CYC out of range 1..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("host_pwr_regs: TIMEOUT out of range 1..65535");
  end

  typedef enum logic [2:0] {
    ST_ON    = 3'd0,
    ST_ISO   = 3'd1,
    ST_SAVE  = 3'd2,
    ST_PDN   = 3'd3,
    ST_OFF   = 3'd4,
    ST_PUP   = 3'd5,
    ST_RST   = 3'd6,
    ST_DEISO = 3'd7
  } pwr_state_e;

  localparam logic [7:0] ISO_LAST = 8'(ISO_CYC - 1);

  // ---------------------------------------------------------------------
  // Input sample stage (S) and strobe edge history
  // ---------------------------------------------------------------------
  logic        s_wr_n, s_rd_n, s_wr_n_q, s_rd_n_q;
  logic [15:0] s_addr, s_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_wr_n   <= 1'b1;
      s_rd_n   <= 1'b1;
      s_wr_n_q <= 1'b1;
      s_rd_n_q <= 1'b1;
      s_addr   <= '0;
      s_data   <= '0;
    end else begin
      s_wr_n   <= wr_n;
      s_rd_n   <= rd_n;
      s_wr_n_q <= s_wr_n;
      s_rd_n_q <= s_rd_n;
      s_addr   <= address;
      s_data   <= data;
    end
  end

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic [15:0] off_full;
  logic [2:0]  offset;
  logic        in_win, wr_fall, rd_fall, both_low;
  logic        wr_hit, rd_hit, err_inc, err_clr, ctrl_wr;

  always_comb begin
    off_full = s_addr - BASE_ADDR;
    in_win   = (off_full[15:3] == 13'd0);
    offset   = off_full[2:0];
    wr_fall  = !s_wr_n && s_wr_n_q;
    rd_fall  = !s_rd_n && s_rd_n_q;
    both_low = !s_wr_n && !s_rd_n;
    wr_hit   = wr_fall && in_win;
    // A read with the write strobe also low is a bus error: no drive.
    rd_hit   = !s_rd_n && s_wr_n && in_win;
    // Counted once per strobe edge, so a held strobe is a single error.
    err_inc  = in_win && (wr_fall || rd_fall) && ((offset >= 3'd5) || both_low);
    err_clr  = wr_hit && (offset == 3'd4);
    ctrl_wr  = wr_hit && (offset == 3'd2);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [15:0] scratch, err_cnt;
  logic        pd_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= '0;
      pd_req  <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (wr_hit && offset == 3'd1) scratch <= s_data;
      if (ctrl_wr)                  pd_req  <= s_data[0];
      // Clear has priority over a coincident increment.
      if (err_clr)
        err_cnt <= '0;
      else if (err_inc && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Power-sequencing FSM
  // ---------------------------------------------------------------------
  pwr_state_e state, state_nx;
  logic [7:0] iso_cnt, iso_cnt_nx;
  logic       iso_nx, save_nx, restore_nx, pwr_off_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_ON;
      iso_cnt <= '0;
      iso_en  <= 1'b0;
      save    <= 1'b0;
      restore <= 1'b0;
      pwr_off <= 1'b0;
    end else begin
      state   <= state_nx;
      iso_cnt <= iso_cnt_nx;
      iso_en  <= iso_nx;
      save    <= save_nx;
      restore <= restore_nx;
      pwr_off <= pwr_off_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    iso_cnt_nx = '0;
    case (state)
      ST_ON:    if (pd_req)               state_nx = ST_ISO;
      ST_ISO:   if (iso_cnt == ISO_LAST)  state_nx = ST_SAVE;
      ST_SAVE:                            state_nx = ST_PDN;
      ST_PDN:   if (!pwr_ack)             state_nx = ST_OFF;
      ST_OFF:   if (!pd_req)              state_nx = ST_PUP;
      ST_PUP:   if (pwr_ack)              state_nx = ST_RST;
      ST_RST:                             state_nx = ST_DEISO;
      ST_DEISO: if (iso_cnt == ISO_LAST)  state_nx = ST_ON;
      default:                            state_nx = ST_ON;
    endcase
    // Settle counter restarts from 0 on every state entry.
    if (state_nx == state && (state == ST_ISO || state == ST_DEISO))
      iso_cnt_nx = iso_cnt + 8'd1;
    // Outputs decoded from the next state so they register on entry.
    iso_nx     = (state_nx != ST_ON);
    save_nx    = (state_nx == ST_SAVE);
    restore_nx = (state_nx == ST_RST);
    pwr_off_nx = (state_nx == ST_PDN) || (state_nx == ST_OFF);
  end

  // ---------------------------------------------------------------------
  // pwr_ack timeout
  // ---------------------------------------------------------------------
  logic to_sticky;

`ifdef HOST_PWR_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
  logic        waiting;

  // Still waiting for the expected pwr_ack edge in PDN or PUP.
  assign waiting = (state_nx == state) && (state == ST_PDN || state == ST_PUP);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      to_sticky <= 1'b0;
    end else begin
      if (!waiting)
        to_cnt <= '0;
      else if (to_cnt != 16'hFFFF)
        to_cnt <= to_cnt + 16'd1;
      if (waiting && to_cnt == TO_LAST)
        to_sticky <= 1'b1;
      if (ctrl_wr)
        to_sticky <= 1'b0;
    end
  end
`else
  assign to_sticky = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read path: mux registered, drive follows one clock behind S
  // ---------------------------------------------------------------------
  logic [15:0] rd_mux, rd_data;
  logic        rd_drv;

  always_comb begin
    rd_mux = '0;
    case (offset)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = scratch;
      3'd2:    rd_mux = {15'd0, pd_req};
      3'd3:    rd_mux = {11'd0, pwr_ack, to_sticky, state};
      3'd4:    rd_mux = err_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_drv  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_drv  <= rd_hit;
      if (rd_hit) rd_data <= rd_mux;
    end
  end

  assign data = rd_drv ? rd_data : 16'bz;

endmodule

// File: doc/host_pwr_regs.md
Name: host_pwr_regs

Overview:
- Host-bus slave on the shared host bus: active-low wr_n/rd_n strobes, 16-bit address, bidirectional 16-bit data.
- Decodes an 8-word register window. Registers hold ID, scratch, power control/status and an error counter.
- Contains the power-sequencing FSM that drives isolation, retention save/restore and the power-switch enable for one switchable domain.

Parameters:
- BASE_ADDR, 16'h0100, window base; decodes BASE_ADDR..BASE_ADDR+7, low 3 address bits are the offset.
- ID_VALUE, 16'hC0DE, read-only ID word.
- ISO_CYC, 4, isolation settle cycles before save / after restore; legal 1..255.
- TIMEOUT, 64, ack timeout in cycles; used only with the optional feature; legal 1..65535.

Ports:
- clk  input  1  bus and block clock.
- reset  input  1  synchronous, active-high reset.
- wr_n  input  1  host write strobe, active low.
- rd_n  input  1  host read strobe, active low.
- address  input  16  host address.
- data  inout  16  host data; driven only during decoded reads, otherwise 'z.
- pwr_ack  input  1  1 = domain powered, 0 = domain off.
- iso_en  output  1  isolation enable.
- save  output  1  retention save pulse.
- restore  output  1  retention restore pulse.
- pwr_off  output  1  power-switch off request.

Behaviour:
- Reset (sync, active-high):
  - Outputs: iso_en=0, save=0, restore=0, pwr_off=0, data='z.
  - Registers: all = 0; FSM = ON.
  - Input sample stage: wr_n/rd_n samples = 1.
- Input sampling: wr_n, rd_n, address, data registered every posedge (stage S). All decode uses S values.
- Write:
  - Trigger: S.wr_n==0 and previous S.wr_n==1 (one write per strobe), address in window.
  - Register updated at the next posedge.
- Read:
  - While S.rd_n==0 and address in window: read mux registered; data driven from the following posedge.
  - Latency: 2 clocks from rd_n low to valid data.
  - Drive released the cycle after S.rd_n returns to 1.
  - Data re-evaluated every cycle while the strobe is held.
- Register map (offset: name, access):
  - 0: ID, RO = ID_VALUE.
  - 1: SCRATCH, RW, 16 bits.
  - 2: PWR_CTRL, RW; bit0 pd_req; other bits read 0.
  - 3: PWR_STAT, RO; [2:0] FSM state code; [3] timeout sticky (optional feature); [4] = pwr_ack.
  - 4: ERR_CNT, RW; a write of any value clears it to 0.
  - Offsets 5-7: undecoded; reads drive 16'h0000.
- Writes to RO registers are ignored.
- ERR_CNT:
  - 16-bit, saturates at 16'hFFFF.
  - +1 per strobe (write or read falling edge) to offsets 5-7.
  - +1 per strobe where wr_n and rd_n are both low in S: write performed, no drive.
  - Same-cycle clear and increment: the clear wins.
- Addresses outside the window: ignored, no drive, no count.
- FSM states (codes 0-7): ON, ISO, SAVE, PDN, OFF, PUP, RST, DEISO.
  - ON (iso_en=0, pwr_off=0): pd_req==1 -> ISO.
  - ISO (iso_en=1): counter runs ISO_CYC cycles -> SAVE.
  - SAVE (iso_en=1, save=1 for exactly one cycle) -> PDN.
  - PDN (iso_en=1, pwr_off=1): pwr_ack==0 -> OFF.
  - OFF (iso_en=1, pwr_off=1): pd_req==0 -> PUP.
  - PUP (iso_en=1, pwr_off=0): pwr_ack==1 -> RST.
  - RST (iso_en=1, restore=1 for exactly one cycle) -> DEISO.
  - DEISO (iso_en=1): ISO_CYC cycles -> ON.
- All FSM outputs are registered, i.e. valid in the same cycle the state is entered.
- pd_req is evaluated only in ON and OFF. Toggling it mid-sequence has no effect until the sequence reaches ON or OFF.
- Reset mid-sequence: immediate return to ON with all power outputs 0. No restore is issued.

Optional Feature:
- Macro: HOST_PWR_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in PDN and PUP; cleared on entry to each.
  - Reaching TIMEOUT without the expected pwr_ack sets PWR_STAT[3] (sticky; cleared by reset or by a PWR_CTRL write).
  - The FSM keeps waiting.
- Undefined: no counter; PWR_STAT[3] reads 0.

Test Plan:
- Reset, then read offset 0 at address 16'h0100 -> data 16'hC0DE from 2 clocks after rd_n low; 'z after release.
- Write 16'hA5A5 to 16'h0101, read back -> 16'hA5A5. Write to 16'h0100 -> ID still 16'hC0DE.
- Write PWR_CTRL=1 with pwr_ack dropping 3 cycles after pwr_off -> iso_en high 4 cycles before a 1-cycle save, pwr_off=1, PWR_STAT[2:0]=4.
- Write PWR_CTRL=0 with pwr_ack rising 5 cycles later -> 1-cycle restore, iso_en low 4 cycles after restore, state 0.
- Reads at 16'h0105 and 16'h0107, plus one strobe with wr_n and rd_n both low -> ERR_CNT=3; write ERR_CNT -> reads 0.
- With HOST_PWR_TIMEOUT_EN, TIMEOUT=64, pwr_ack held 1 in PDN -> PWR_STAT[3]=1 at cycle 64, state stays PDN. Assert reset -> state ON, pwr_off=0.
